fb_scanout: RTL and testbench
=============================

# fb_scanout

Display-side consumer of the 160x120x3-bit frame buffer written by the line painter. Generates 640x480@60 Hz VGA timing from the 50 MHz system clock, reads each frame-buffer pixel through a one-cycle-latency read port, and replicates it 4x4 on screen. Owns the double-buffer selection: it reports which buffer is displayed and which the painter may draw into, and swaps them only at the start of vertical blanking.

## Interface
- `H_VIS`, 640: visible pixels per line
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal porches and sync, in pixels
- `V_VIS`, 480: visible lines
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical porches and sync, in lines
- `clk` input 1: 50 MHz system clock
- `reset` input 1: asynchronous, active-high
- `fb_addr` output 15: frame-buffer read address, `row*160+col`
- `fb_data` input 3: frame-buffer read data, valid one clk after `fb_addr`
- `swap_req` input 1: level; CPU requests a buffer swap
- `swap_ack` output 1: one-clk pulse when the swap is taken
- `disp_buf` output 1: buffer currently scanned out
- `draw_buf` output 1: always `~disp_buf`; routed to the painter-side buffer select
- `rgb` output 3: {R,G,B}, one bit each
- `hsync` output 1: active low
- `vsync` output 1: active low
- `frame_start` output 1: one-clk pulse at hcnt=0, vcnt=0

## Operation
- `pix_en` toggles every clk, giving a 25 MHz pixel rate. Phase is 0 after reset, so the first `pix_en`=1 occurs on the first clk after reset.
- Counters:
  - `hcnt` counts 0..799 and `vcnt` counts 0..524; both advance only on `pix_en`.
  - `hcnt` wraps to 0 at 799 and increments `vcnt`.
  - `vcnt` wraps to 0 at 524.
- Address generation, on `pix_en`:
  - `row = vcnt[8:2]` (0..119), `col = hcnt[9:2]` (0..159).
  - `fb_addr <= (row<<7)+(row<<5)+col`, computed at 15 bits. Maximum is 19199 and the result never overflows.
  - Outside the visible area, `fb_addr` holds its last value.
- On the clk after `pix_en`, `fb_data` is captured into `pix_q`.
- Output stage, on the next `pix_en`: `rgb`, `hsync` and `vsync` all update together from the delayed counter state.
  - `rgb` = `pix_q` when visible (hcnt<640 and vcnt<480), otherwise 3'b000.
  - `hsync` is low for hcnt 656..751.
  - `vsync` is low for vcnt 490..491.
- Swap:
  - On the `pix_en` where hcnt=0 and vcnt=480, if `swap_req`=1: toggle `disp_buf` and pulse `swap_ack` for one clk.
  - If `swap_req` is deasserted before that point, no swap occurs.
  - `swap_req` held high across several frames swaps once per frame. The CPU must drop it after `swap_ack`.
- `reset` asserted mid-frame forces all state to reset values immediately, with no clk edge required. Scan resumes from hcnt=0, vcnt=0.
- Reset values: `fb_addr`=0, `rgb`=0, `hsync`=1, `vsync`=1, `disp_buf`=0, `draw_buf`=1, `swap_ack`=0, `frame_start`=0. Internal counters, `pix_q` and the phase are all 0.

## Timing
- Pipeline latency from counter state to pins is one pixel period (2 clk), identical for `rgb`, `hsync` and `vsync`.
- Line period is 1600 clk; frame period is 840000 clk.
- Within a line, the hsync low pulse is 192 clk long.
- Within a frame, the vsync low pulse is 3200 clk long.
- `swap_ack` and `frame_start` are single-clk pulses aligned to a `pix_en` edge.
- `disp_buf` changes only inside vertical blanking, so the painter never tears a displayed frame.

## Configuration
- `FB_SCANOUT_DOUBLE_BUF_EN` defined: swap logic as above.
- `FB_SCANOUT_DOUBLE_BUF_EN` undefined:
  - `disp_buf` is tied 0 and `draw_buf` is tied 0 (single shared buffer).
  - `swap_ack` is tied 0 and `swap_req` is ignored.

## Structure
- Shared package holds:
  - the VGA timing constants (visible, porch and sync values, totals 800/525);
  - `FB_W`=160, `FB_H`=120, `FB_DEPTH`=19200;
  - the pixel type `pix_t` (3 bits).
- Sub-module `vga_timing` contains `pix_en`, `hcnt`/`vcnt`, raw sync and the visible flag. `fb_scanout` adds address generation, the data pipeline and swap control.

## Test plan
- **Reset release:** first `hsync` fall occurs 1312+2 clk after reset deasserts; `hsync` stays low 192 clk; next fall is 1600 clk later.
- **Vertical timing:** `vsync` is low for exactly 2 lines starting at line 490; `frame_start` pulses every 840000 clk.
- **Pixel mapping**, with frame-buffer model `fb[a]=a[2:0]`:
  - screen (0..3, 0..3) shows 0;
  - (4,0) shows fb[1]=1;
  - (0,4) shows fb[160]=0;
  - (639,479) drives `fb_addr`=19199 and shows 7.
- **Blanking:** `rgb`=000 for hcnt 640..799 and for vcnt 480..524, with fb model all 3'b111.
- **Swap:**
  - `swap_req` raised at line 300 → `disp_buf` 0→1 and one-clk `swap_ack` at line 480 start; `draw_buf`=0.
  - `swap_req` dropped at line 479 → no swap.
  - With the macro undefined, `disp_buf` and `swap_ack` stay 0.
- **Async reset at hcnt=400:** outputs return to reset values before the next clk edge; after release, timing restarts as in the reset-release scenario.

Source files
------------

// File: rtl/fb_scanout_pkg.sv
// Shared VGA timing constants, frame-buffer geometry and pixel types for fb_scanout.
package fb_scanout_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;  // 800

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;  // 525

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int FB_AW    = 15;
  localparam int CNT_W    = 10;

  typedef logic [2:0]       pix_t;
  typedef logic [FB_AW-1:0] fb_addr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Per-pixel scan state that travels down the output pipeline.
  typedef struct packed {
    logic visible;
    logic hsync_n;
    logic vsync_n;
  } scan_ctl_t;

  localparam scan_ctl_t SCAN_CTL_RST = '{visible: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

  // row*160 + col using shifts only; fits in 15 bits for row<120, col<160.
  function automatic fb_addr_t fb_index(input logic [6:0] row, input logic [7:0] col);
    return (fb_addr_t'(row) << 7) + (fb_addr_t'(row) << 5) + fb_addr_t'(col);
  endfunction

endpackage

// File: rtl/fb_scanout_vga_timing.sv
// VGA raster generator: 25 MHz pixel enable from a 50 MHz clock, h/v counters,
// raw active-low syncs and the visible-area flag.
module vga_timing
  import fb_scanout_pkg::*;
#(
  parameter int H_VIS  = fb_scanout_pkg::H_VIS,
  parameter int H_FP   = fb_scanout_pkg::H_FP,
  parameter int H_SYNC = fb_scanout_pkg::H_SYNC,
  parameter int H_BP   = fb_scanout_pkg::H_BP,
  parameter int V_VIS  = fb_scanout_pkg::V_VIS,
  parameter int V_FP   = fb_scanout_pkg::V_FP,
  parameter int V_SYNC = fb_scanout_pkg::V_SYNC,
  parameter int V_BP   = fb_scanout_pkg::V_BP
) (
  input  logic      clk,
  input  logic      reset,
  output logic      pix_en,
  output cnt_t      hcnt,
  output cnt_t      vcnt,
  output scan_ctl_t ctl
);

  localparam cnt_t H_LAST  = cnt_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST  = cnt_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t H_VIS_C = cnt_t'(H_VIS);
  localparam cnt_t V_VIS_C = cnt_t'(V_VIS);
  localparam cnt_t HS_BEG  = cnt_t'(H_VIS + H_FP);
  localparam cnt_t HS_END  = cnt_t'(H_VIS + H_FP + H_SYNC);
  localparam cnt_t VS_BEG  = cnt_t'(V_VIS + V_FP);
  localparam cnt_t VS_END  = cnt_t'(V_VIS + V_FP + V_SYNC);

  logic phase_q, phase_d;
  cnt_t hcnt_q, hcnt_d;
  cnt_t vcnt_q, vcnt_d;

  // Phase 0 after reset makes the very first clk a pixel clk.
  assign pix_en = ~phase_q;

  always_comb begin
    // NOTE: every _d starts from its hold value so no branch can leave it unassigned and infer a latch.
    phase_d = ~phase_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    if (pix_en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    ctl.visible = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
    ctl.hsync_n = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    ctl.vsync_n = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= 1'b0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      phase_q <= phase_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  assign hcnt = hcnt_q;
  assign vcnt = vcnt_q;

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scanout: 4x4-replicated 160x120 image on 640x480@60 VGA, with
// double-buffer swap at the start of vblank when FB_SCANOUT_DOUBLE_BUF_EN is defined.
module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter int H_VIS  = fb_scanout_pkg::H_VIS,
  parameter int H_FP   = fb_scanout_pkg::H_FP,
  parameter int H_SYNC = fb_scanout_pkg::H_SYNC,
  parameter int H_BP   = fb_scanout_pkg::H_BP,
  parameter int V_VIS  = fb_scanout_pkg::V_VIS,
  parameter int V_FP   = fb_scanout_pkg::V_FP,
  parameter int V_SYNC = fb_scanout_pkg::V_SYNC,
  parameter int V_BP   = fb_scanout_pkg::V_BP
) (
  input  logic             clk,
  input  logic             reset,
  output logic [FB_AW-1:0] fb_addr,
  input  logic [2:0]       fb_data,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic             disp_buf,
  output logic             draw_buf,
  output logic [2:0]       rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  logic      pix_en;
  cnt_t      hcnt, vcnt;
  scan_ctl_t ctl_raw;

  vga_timing #(
    .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk    (clk),
    .reset  (reset),
    .pix_en (pix_en),
    .hcnt   (hcnt),
    .vcnt   (vcnt),
    .ctl    (ctl_raw)
  );

  fb_addr_t  fb_addr_q, fb_addr_d;
  pix_t      pix_q, pix_d;
  scan_ctl_t ctl_q, ctl_d;
  pix_t      rgb_q, rgb_d;
  logic      hsync_q, hsync_d;
  logic      vsync_q, vsync_d;
  logic      frame_start_q, frame_start_d;

  // pix_en clk: issue the address and stage scan state; next clk: capture read data.
  // rgb and both syncs leave from the same staged state, so they stay aligned.
  always_comb begin
    fb_addr_d     = fb_addr_q;
    pix_d         = pix_q;
    ctl_d         = ctl_q;
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      if (ctl_raw.visible) begin
        fb_addr_d = fb_index(vcnt[8:2], hcnt[9:2]);
      end
      ctl_d         = ctl_raw;
      rgb_d         = ctl_q.visible ? pix_q : '0;
      hsync_d       = ctl_q.hsync_n;
      vsync_d       = ctl_q.vsync_n;
      frame_start_d = (hcnt == '0) && (vcnt == '0);
    end else begin
      pix_d = fb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_addr_q     <= '0;
      pix_q         <= '0;
      ctl_q         <= SCAN_CTL_RST;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      fb_addr_q     <= fb_addr_d;
      pix_q         <= pix_d;
      ctl_q         <= ctl_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

`ifdef FB_SCANOUT_DOUBLE_BUF_EN
  localparam cnt_t V_SWAP = cnt_t'(V_VIS);

  logic disp_buf_q, disp_buf_d;
  logic swap_ack_q, swap_ack_d;

  // Swap only on the first pixel of vblank so a displayed frame never tears.
  always_comb begin
    swap_ack_d = pix_en && swap_req && (hcnt == '0) && (vcnt == V_SWAP);
    disp_buf_d = disp_buf_q ^ swap_ack_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_buf_q <= 1'b0;
      swap_ack_q <= 1'b0;
    end else begin
      disp_buf_q <= disp_buf_d;
      swap_ack_q <= swap_ack_d;
    end
  end

  assign disp_buf = disp_buf_q;
  assign draw_buf = ~disp_buf_q;
  assign swap_ack = swap_ack_q;
`else
  // Single shared buffer: painter and scanout both use buffer 0.
  logic unused_swap_req;
  assign unused_swap_req = swap_req;
  assign disp_buf        = 1'b0;
  assign draw_buf        = 1'b0;
  assign swap_ack        = 1'b0;
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout: a full-size instance for line timing, pixel
// mapping and async reset, plus a reduced-geometry instance scoreboarded over whole frames.
`timescale 1ns/1ps
module tb_fb_scanout;
  import fb_scanout_pkg::*;

  // Reduced raster so several complete frames fit in a short run.
  localparam int SH_VIS = 32, SH_FP = 4, SH_SYNC = 8, SH_BP = 4;
  localparam int SV_VIS = 16, SV_FP = 2, SV_SYNC = 2, SV_BP = 4;
  localparam int SH_TOT = SH_VIS + SH_FP + SH_SYNC + SH_BP;
  localparam int SV_TOT = SV_VIS + SV_FP + SV_SYNC + SV_BP;
  localparam int S_FRAMES = 5;
  localparam int S_TICKS  = S_FRAMES * SH_TOT * SV_TOT;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- full-size instance ----------------
  logic             rst_f = 1'b0;
  logic [FB_AW-1:0] f_addr;
  logic [2:0]       f_data, f_rgb;
  logic             f_ack, f_disp, f_draw, f_hs, f_vs, f_fs;

  assign f_data = f_addr[2:0];  // fb[a] = a[2:0]

  fb_scanout u_full (
    .clk (clk), .reset (rst_f), .fb_addr (f_addr), .fb_data (f_data),
    .swap_req (1'b0), .swap_ack (f_ack), .disp_buf (f_disp), .draw_buf (f_draw),
    .rgb (f_rgb), .hsync (f_hs), .vsync (f_vs), .frame_start (f_fs)
  );

  // ---------------- reduced instance ----------------
  logic             rst_s = 1'b0;
  logic             s_req = 1'b0;
  logic [FB_AW-1:0] s_addr;
  logic [2:0]       s_data, s_rgb;
  logic             s_ack, s_disp, s_draw, s_hs, s_vs, s_fs;
  logic [2:0]       mem0 [0:FB_DEPTH-1];
  logic [2:0]       mem1 [0:FB_DEPTH-1];

  assign s_data = s_disp ? mem1[s_addr] : mem0[s_addr];

  fb_scanout #(
    .H_VIS (SH_VIS), .H_FP (SH_FP), .H_SYNC (SH_SYNC), .H_BP (SH_BP),
    .V_VIS (SV_VIS), .V_FP (SV_FP), .V_SYNC (SV_SYNC), .V_BP (SV_BP)
  ) u_small (
    .clk (clk), .reset (rst_s), .fb_addr (s_addr), .fb_data (s_data),
    .swap_req (s_req), .swap_ack (s_ack), .disp_buf (s_disp), .draw_buf (s_draw),
    .rgb (s_rgb), .hsync (s_hs), .vsync (s_vs), .frame_start (s_fs)
  );

  logic exp_draw_rst;
`ifdef FB_SCANOUT_DOUBLE_BUF_EN
  assign exp_draw_rst = 1'b1;
`else
  assign exp_draw_rst = 1'b0;
`endif

  // ---------------- full-size directed checks ----------------
  int f_edge = 0;  // clk edges since the last reset release

  task automatic f_step_to(input int e);
    while (f_edge < e) begin
      @(posedge clk);
      f_edge++;
    end
    @(negedge clk);
  endtask

  task automatic check_full_reset(input string tag);
    check({tag, "_rgb"},         f_rgb,  0);
    check({tag, "_fb_addr"},     f_addr, 0);
    check({tag, "_hsync"},       f_hs,   1);
    check({tag, "_vsync"},       f_vs,   1);
    check({tag, "_disp_buf"},    f_disp, 0);
    check({tag, "_draw_buf"},    f_draw, exp_draw_rst);
    check({tag, "_swap_ack"},    f_ack,  0);
    check({tag, "_frame_start"}, f_fs,   0);
  endtask

  // Screen pixel (x,y) is on the pins after clk edge 2*(y*800+x)+3.
  task automatic check_pix(input string tag, input int x, input int y, input int exp_addr);
    int exp_rgb;
    f_step_to(2 * (y * H_TOTAL + x) + 3);
    exp_rgb = (x < H_VIS && y < V_VIS) ? (((y / 4) * FB_W + (x / 4)) % 8) : 0;
    check($sformatf("%s_rgb_%0d_%0d", tag, x, y), f_rgb, exp_rgb);
    if (exp_addr >= 0) check($sformatf("%s_addr_%0d_%0d", tag, x, y), f_addr, exp_addr);
  endtask

  task automatic scan_checks(input string tag);
    int fall, rise, fall2;
    fall = -1; rise = -1; fall2 = -1;
    f_step_to(1);
    check({tag, "_frame_start_first"}, f_fs, 1);
    f_step_to(2);
    check({tag, "_frame_start_pulse"}, f_fs, 0);
    check_pix(tag, 0, 0, -1);
    check_pix(tag, 3, 0, -1);
    check_pix(tag, 4, 0, -1);
    check_pix(tag, 28, 0, -1);
    check_pix(tag, 639, 0, 159);
    while (fall < 0 && f_edge < 3000) begin
      f_step_to(f_edge + 1);
      if (f_hs === 1'b0) fall = f_edge;
    end
    check({tag, "_hsync_fall_clks"}, fall - 1, 1312 + 2);  // counted from the first active edge
    while (rise < 0 && f_edge < 3400) begin
      f_step_to(f_edge + 1);
      if (f_hs === 1'b1) rise = f_edge;
    end
    check({tag, "_hsync_low_clks"}, rise - fall, 192);
    while (fall2 < 0 && f_edge < 6000) begin
      f_step_to(f_edge + 1);
      if (f_hs === 1'b0) fall2 = f_edge;
    end
    check({tag, "_hsync_period_clks"}, fall2 - fall, 1600);
    check_pix(tag, 3, 3, -1);
    check_pix(tag, 0, 4, -1);
    check_pix(tag, 5, 4, -1);
    check_pix(tag, 12, 4, -1);
    check_pix(tag, 639, 4, 319);
    check_pix(tag, 700, 4, 319);
    check_pix(tag, 0, 5, -1);
    check_pix(tag, 17, 6, -1);
    check({tag, "_vsync_early"}, f_vs, 1);
  endtask

  task automatic run_full();
    #1 rst_f = 1'b1;
    @(negedge clk);
    check_full_reset("por");
    rst_f  = 1'b0;
    f_edge = 0;
    scan_checks("por");
    // Line 6, hcnt=400: the pins show (399,6) -> fb[259].
    f_step_to(2 * (6 * H_TOTAL + 400) + 1);
    check("pre_async_rgb", f_rgb, 3);
    #2 rst_f = 1'b1;
    #1 check_full_reset("async");
    @(posedge clk);
    @(negedge clk);
    check_full_reset("async_held");
    rst_f  = 1'b0;
    f_edge = 0;
    scan_checks("rerun");
  endtask

  // ---------------- reduced-instance scoreboard ----------------
  typedef struct {
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
  } pix_exp_t;

  typedef struct {
    logic disp;
    logic draw;
    logic ack;
    logic fs;
  } ctl_exp_t;

  pix_exp_t pix_sb[$];
  ctl_exp_t ctl_sb[$];

  // Stimulus + model: tick t is the raster position held during clk edge 2t+1.
  task automatic run_small();
    logic disp;
    disp = 1'b0;
    rst_s = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_s = 1'b0;
    for (int t = 0; t < S_TICKS; t++) begin
      int h, v, f, addr;
      logic vis;
      pix_exp_t pe;
      ctl_exp_t ce;
      h = t % SH_TOT;
      v = (t / SH_TOT) % SV_TOT;
      f = t / (SH_TOT * SV_TOT);
      if (h == 0) begin
        if (f == 0)      s_req = (v >= 5);           // raised mid-frame, held through vblank start
        else if (f == 1) s_req = (v < SV_VIS - 1);   // dropped on the last visible line
        else             s_req = 1'($urandom_range(0, 1));
      end
      ce.ack = 1'b0;
`ifdef FB_SCANOUT_DOUBLE_BUF_EN
      if (h == 0 && v == SV_VIS && s_req) begin
        disp   = !disp;
        ce.ack = 1'b1;
      end
      ce.draw = !disp;
`else
      ce.draw = 1'b0;
`endif
      ce.disp = disp;
      ce.fs   = (h == 0 && v == 0);
      ctl_sb.push_back(ce);
      vis  = (h < SH_VIS) && (v < SV_VIS);
      addr = (v / 4) * FB_W + (h / 4);
      pe.rgb = vis ? (disp ? mem1[addr] : mem0[addr]) : 3'b000;
      pe.hs  = !(h >= SH_VIS + SH_FP && h < SH_VIS + SH_FP + SH_SYNC);
      pe.vs  = !(v >= SV_VIS + SV_FP && v < SV_VIS + SV_FP + SV_SYNC);
      pix_sb.push_back(pe);
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  // Monitor: control outputs are due right after each pixel edge, rgb/syncs one pixel later.
  task automatic monitor_small();
    wait (rst_s === 1'b1);
    wait (rst_s === 1'b0);
    for (int e = 1; e <= 2 * S_TICKS + 1; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e % 2 == 1) begin
        if (e <= 2 * S_TICKS - 1) begin
          if (ctl_sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL ctl_scoreboard_empty: edge %0d", e);
          end else begin
            ctl_exp_t c;
            c = ctl_sb.pop_front();
            check($sformatf("disp_buf@%0d", e),    s_disp, c.disp);
            check($sformatf("draw_buf@%0d", e),    s_draw, c.draw);
            check($sformatf("swap_ack@%0d", e),    s_ack,  c.ack);
            check($sformatf("frame_start@%0d", e), s_fs,   c.fs);
          end
        end
        if (e >= 3) begin
          if (pix_sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL pix_scoreboard_empty: edge %0d", e);
          end else begin
            pix_exp_t p;
            p = pix_sb.pop_front();
            check($sformatf("rgb@%0d", e),   s_rgb, p.rgb);
            check($sformatf("hsync@%0d", e), s_hs,  p.hs);
            check($sformatf("vsync@%0d", e), s_vs,  p.vs);
          end
        end
      end else begin
        check($sformatf("swap_ack_width@%0d", e),    s_ack, 0);
        check($sformatf("frame_start_width@%0d", e), s_fs,  0);
      end
    end
    check("scoreboard_drained", pix_sb.size() + ctl_sb.size(), 0);
  endtask

  initial begin
    for (int a = 0; a < FB_DEPTH; a++) begin
      mem0[a] = 3'($urandom);
      mem1[a] = 3'($urandom);
    end
    fork
      run_full();
      run_small();
      monitor_small();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
